store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer_pkg.sv | 14 +
 rtl/sb_fwd_match.sv | 30 +++
 rtl/store_buffer.sv | 100 ++++++++++
 tb/tb_store_buffer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared sizing and entry record for the CPU-side store buffer.
// The buffer and its forwarding matcher both import this package.
package store_buffer_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_AW    = 8;
  localparam int SB_DW    = 32;

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-match search over the live window [head, head+count) of the store buffer.
// Walks oldest to youngest so the last match found wins.
module sb_fwd_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  sb_entry_t        entries [DEPTH],
  input  logic [PW-1:0]    head,
  input  logic [CW-1:0]    count,
  input  logic [AW-1:0]    key,
  output logic             hit,
  output logic [PW-1:0]    idx
);

  always_comb begin
    hit = 1'b0;
    idx = head;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < count) && (entries[PW'(head + PW'(k))].addr == key)) begin
        hit = 1'b1;
        idx = PW'(head + PW'(k));
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between the CPU datapath and DataMemory: stores queue here and drain
// in program order whenever the memory port is not needed by a load.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_ready,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  output logic [31:0] ld_data,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic        mem_re,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t      ent [DEPTH];
  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic [CW-1:0]  count;
  logic           push;
  logic           pop;
  logic           fwd_hit;
  logic [PW-1:0]  fwd_idx;
  logic           unused_addr_bits;

  // Only the word-index bits take part in compare and drain.
  assign unused_addr_bits = ^{st_addr[31:AW], ld_addr[31:AW]};

  assign st_ready = (count != CW'(DEPTH));
  assign empty    = (count == '0);
  assign push     = st_valid && st_ready;
  assign pop      = !ld_valid && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry payload needs no reset; the matcher only looks inside count.
  always_ff @(posedge clk) begin
    if (push) begin
      ent[tail].addr <= st_addr[AW-1:0];
      ent[tail].data <= st_data;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ld_valid) begin
      mem_re   = 1'b1;
      mem_addr = ld_addr;
    end else if (!empty) begin
      mem_we    = 1'b1;
      mem_addr  = 32'(ent[head].addr);
      mem_wdata = ent[head].data;
    end
  end

  sb_fwd_match #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fwd_match (
    .entries (ent),
    .head    (head),
    .count   (count),
    .key     (ld_addr[AW-1:0]),
    .hit     (fwd_hit),
    .idx     (fwd_idx)
  );

  assign ld_data = fwd_hit ? ent[fwd_idx].data : mem_rdata;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: expected memory writes queue up as stores are
// issued and are checked in order as the buffer drains them.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        empty;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t wq[$];
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  store_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .st_valid  (st_valid),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_ready  (st_ready),
    .ld_valid  (ld_valid),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .empty     (empty)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input bit expected);
    wr_t w;
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    if (expected) begin
      w.addr = a & 32'h0000_00FF;
      w.data = d;
      wq.push_back(w);
    end
  endtask

  // One clock: scoreboard the write port at the negedge, return at posedge+1.
  task automatic cycle();
    wr_t e;
    @(negedge clk);
    if (mem_we) begin
      if (wq.size() == 0) begin
        chk("unexpected_write", 32'(mem_we), 32'd0);
      end else begin
        e = wq.pop_front();
        chk("wr_addr", mem_addr, e.addr);
        chk("wr_data", mem_wdata, e.data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0;
    ld_valid = 1'b0; ld_addr = '0; mem_rdata = '0;
    #2;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_ready", 32'(st_ready), 32'd1);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_re", 32'(mem_re), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Scenario 1: single store drains on the next cycle
    store(32'h10, 32'h1111_1111, 1'b1);
    #1;
    chk("s1_ready", 32'(st_ready), 32'd1);
    chk("s1_we_before", 32'(mem_we), 32'd0);
    cycle();
    st_valid = 1'b0;
    #1;
    chk("s1_we", 32'(mem_we), 32'd1);
    chk("s1_addr", mem_addr, 32'h10);
    chk("s1_wdata", mem_wdata, 32'h1111_1111);
    chk("s1_not_empty", 32'(empty), 32'd0);
    cycle();
    chk("s1_empty", 32'(empty), 32'd1);

    // Scenario 2: load holds the port while the buffer fills
    ld_valid = 1'b1; ld_addr = 32'h80; mem_rdata = 32'h5555_5555;
    for (int i = 0; i < 4; i++) begin
      store(32'h40 + i, 32'h400 + i, 1'b1);
      #1;
      chk("s2_re", 32'(mem_re), 32'd1);
      chk("s2_we", 32'(mem_we), 32'd0);
      chk("s2_ready", 32'(st_ready), 32'd1);
      cycle();
    end
    store(32'h44, 32'h404, 1'b0);
    #1;
    chk("s2_full", 32'(st_ready), 32'd0);
    chk("s2_ld_miss", ld_data, 32'h5555_5555);
    ld_addr = 32'h41;
    #1;
    chk("s2_fwd", ld_data, 32'h401);
    cycle();
    chk("s2_still_full", 32'(st_ready), 32'd0);
    st_valid = 1'b0; ld_valid = 1'b0;
    repeat (4) cycle();
    chk("s2_empty", 32'(empty), 32'd1);
    chk("s2_drained", 32'(wq.size()), 32'd0);

    // Scenario 3/4: youngest-match forwarding and memory fallback
    ld_valid = 1'b1; ld_addr = 32'h80;
    store(32'h20, 32'hA, 1'b1);
    cycle();
    store(32'h20, 32'hB, 1'b1);
    cycle();
    st_valid = 1'b0; ld_addr = 32'h20; mem_rdata = 32'hCAFE_F00D;
    #1;
    chk("s3_fwd", ld_data, 32'hB);
    chk("s3_re", 32'(mem_re), 32'd1);
    chk("s3_addr", mem_addr, 32'h20);
    ld_addr = 32'h120;
    #1;
    chk("s3_alias", ld_data, 32'hB);
    ld_addr = 32'h20;
    store(32'h20, 32'hC, 1'b1);
    #1;
    chk("s3_same_cycle", ld_data, 32'hB);
    cycle();
    st_valid = 1'b0;
    #1;
    chk("s3_fwd_c", ld_data, 32'hC);
    ld_addr = 32'h30; mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("s4_miss", ld_data, 32'hDEAD_BEEF);
    ld_valid = 1'b0;
    repeat (3) cycle();
    chk("s3_empty", 32'(empty), 32'd1);

    // Head entry still forwards while it drains
    store(32'h60, 32'h66, 1'b1);
    cycle();
    st_valid = 1'b0; ld_addr = 32'h60; mem_rdata = 32'h0;
    #1;
    chk("head_fwd", ld_data, 32'h66);
    chk("head_we", 32'(mem_we), 32'd1);
    cycle();
    chk("head_empty", 32'(empty), 32'd1);

    // Scenario 5: steady push+pop at count=2 wraps pointers in order
    ld_valid = 1'b1; ld_addr = 32'h80;
    store(32'h50, 32'h500, 1'b1);
    cycle();
    store(32'h51, 32'h501, 1'b1);
    cycle();
    ld_valid = 1'b0;
    for (int i = 2; i < 9; i++) begin
      store(32'h50 + i, 32'h500 + i, 1'b1);
      #1;
      chk("s5_we", 32'(mem_we), 32'd1);
      chk("s5_ready", 32'(st_ready), 32'd1);
      cycle();
      chk("s5_pending", 32'(empty), 32'd0);
    end
    st_valid = 1'b0;
    cycle();
    chk("s5_one_left", 32'(empty), 32'd0);
    cycle();
    chk("s5_empty", 32'(empty), 32'd1);
    chk("s5_drained", 32'(wq.size()), 32'd0);

    // Scenario 6: async reset mid-drain discards pending stores
    ld_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      store(32'h70 + i, 32'h700 + i, 1'b1);
      cycle();
    end
    st_valid = 1'b0; ld_valid = 1'b0;
    #1;
    chk("s6_draining", 32'(mem_we), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("s6_empty", 32'(empty), 32'd1);
    chk("s6_we", 32'(mem_we), 32'd0);
    chk("s6_ready", 32'(st_ready), 32'd1);
    wq.delete();
    store(32'h77, 32'h777, 1'b0);
    repeat (2) cycle();
    st_valid = 1'b0;
    rst = 1'b1;
    repeat (5) cycle();
    chk("s6_ignored", 32'(empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
